// File: rtl/db9md_pkg.sv
// Shared constants for the Mega Drive DB9 pad reader.
//   - Button bit positions in the core's 16-bit joystick word.
//   - Scanner state encoding.
//   - Protocol step indices at which pad data is sampled.
package db9md_pkg;

  // Joystick word layout (active-high); bits [15:12] stay zero
  localparam int unsigned BIT_R     = 0;
  localparam int unsigned BIT_L     = 1;
  localparam int unsigned BIT_D     = 2;
  localparam int unsigned BIT_U     = 3;
  localparam int unsigned BIT_A     = 4;
  localparam int unsigned BIT_B     = 5;
  localparam int unsigned BIT_C     = 6;
  localparam int unsigned BIT_X     = 7;
  localparam int unsigned BIT_Y     = 8;
  localparam int unsigned BIT_Z     = 9;
  localparam int unsigned BIT_START = 10;
  localparam int unsigned BIT_MODE  = 11;

  localparam int unsigned JOY_W  = 16;
  localparam int unsigned STEP_W = 3;

  // Step indices within one player's 8-step select sequence
  localparam logic [STEP_W-1:0] STEP_DIR    = 3'd0;
  localparam logic [STEP_W-1:0] STEP_ASTART = 3'd1;
  localparam logic [STEP_W-1:0] STEP_SIXCHK = 3'd5;
  localparam logic [STEP_W-1:0] STEP_XYZ    = 3'd6;
  localparam logic [STEP_W-1:0] STEP_LAST   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SWAP = 2'd2
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/db9md_step_timer.sv
// Tick counter with a last-tick pulse plus a 3-bit protocol step counter.
//   clk, reset : clock, synchronous active-high reset
//   step_en    : advance the step counter when the tick counter wraps
//   limit      : last tick value of the current period (period = limit + 1)
//   step       : current protocol step, wraps 7 -> 0
//   last_c     : combinational, high on the final tick of the period
import db9md_pkg::*;

module db9md_step_timer #(
  parameter int unsigned W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_en,
  input  logic [W-1:0]      limit,
  output logic [STEP_W-1:0] step,
  output logic              last_c
);

  logic [W-1:0] tick;

  assign last_c = (tick == limit);

  // Period restarts automatically on wrap; the owner only swaps the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= '0;
      step <= '0;
    end else if (last_c) begin
      tick <= '0;
      if (step_en) step <= step + STEP_W'(1);
    end else begin
      tick <= tick + W'(1);
    end
  end

endmodule

// File: rtl/db9md_pad_reader.sv
// Scans two Mega Drive 3/6-button pads through the shared DB9 port.
//   clk, reset   : joystick clock, synchronous active-high reset
//   joy_in       : pad lines D5..D0, active-low
//   joy_mdsel    : pad SELECT line
//   joy_split    : port mux select, 0 = player 1, 1 = player 2
//   joystick1/2  : committed active-high button words per player
//   present      : pad detected per player
//   six_btn      : 6-button pad detected per player
//   frame_strobe : one-cycle pulse after both players are committed
import db9md_pkg::*;

module db9md_pad_reader #(
  parameter int unsigned STEP_CYCLES = 200,
  parameter int unsigned IDLE_CYCLES = 85000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       joy_in,
  output logic             joy_mdsel,
  output logic             joy_split,
  output logic [JOY_W-1:0] joystick1,
  output logic [JOY_W-1:0] joystick2,
  output logic [1:0]       present,
  output logic [1:0]       six_btn,
  output logic             frame_strobe
);

  localparam int unsigned TW = $clog2(max_u(IDLE_CYCLES, STEP_CYCLES));
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_CYCLES - 1);
  localparam logic [TW-1:0] STEP_END  = TW'(STEP_CYCLES - 1);

  logic [5:0]       sync_a;
  logic [5:0]       sync_b;
  logic [5:0]       d_c;
  state_t           state;
  logic             player;
  logic [JOY_W-1:0] shadow;
  logic             present_sh;
  logic             six_sh;
  logic             last_c;
  logic             scan_c;
  logic [STEP_W-1:0] step;
  logic [TW-1:0]    limit_c;

  // Two-flop synchronizer; idle lines are high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= joy_in;
      sync_b <= sync_a;
    end
  end

  assign d_c     = ~sync_b;
  assign scan_c  = (state == SCAN);
  assign limit_c = (state == IDLE) ? IDLE_LAST : STEP_END;

  db9md_step_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .step_en (scan_c),
    .limit   (limit_c),
    .step    (step),
    .last_c  (last_c)
  );

  // Scanner: IDLE -> SCAN(p0) -> SWAP -> SCAN(p1) -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      player       <= 1'b0;
      joy_mdsel    <= 1'b1;
      joy_split    <= 1'b0;
      shadow       <= '0;
      present_sh   <= 1'b0;
      six_sh       <= 1'b0;
      joystick1    <= '0;
      joystick2    <= '0;
      present      <= '0;
      six_btn      <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      case (state)
        IDLE: begin
          joy_mdsel <= 1'b1;
          if (last_c) begin
            state      <= SCAN;
            player     <= 1'b0;
            joy_split  <= 1'b0;
            shadow     <= '0;
            present_sh <= 1'b0;
            six_sh     <= 1'b0;
          end
        end

        SWAP: begin
          if (last_c) begin
            state      <= SCAN;
            player     <= 1'b1;
            joy_mdsel  <= 1'b1;
            shadow     <= '0;
            present_sh <= 1'b0;
            six_sh     <= 1'b0;
          end
        end

        SCAN: begin
          if (last_c) begin
            case (step)
              STEP_DIR: begin
                shadow[BIT_U] <= d_c[0];
                shadow[BIT_D] <= d_c[1];
                shadow[BIT_L] <= d_c[2];
                shadow[BIT_R] <= d_c[3];
                shadow[BIT_B] <= d_c[4];
                shadow[BIT_C] <= d_c[5];
              end
              STEP_ASTART: begin
                // A pad pulls L and R low while SELECT is low
                present_sh        <= d_c[2] & d_c[3];
                shadow[BIT_A]     <= d_c[4];
                shadow[BIT_START] <= d_c[5];
              end
              STEP_SIXCHK: six_sh <= &d_c[3:0];
              STEP_XYZ: begin
                shadow[BIT_Z]    <= six_sh & d_c[0];
                shadow[BIT_Y]    <= six_sh & d_c[1];
                shadow[BIT_X]    <= six_sh & d_c[2];
                shadow[BIT_MODE] <= six_sh & d_c[3];
              end
              default: ;
            endcase

            if (step == STEP_LAST) begin
              joy_mdsel <= 1'b1;
              if (!player) begin
                joystick1  <= present_sh ? shadow : '0;
                present[0] <= present_sh;
                six_btn[0] <= present_sh & six_sh;
                state      <= SWAP;
                joy_split  <= 1'b1;
              end else begin
                joystick2    <= present_sh ? shadow : '0;
                present[1]   <= present_sh;
                six_btn[1]   <= present_sh & six_sh;
                state        <= IDLE;
                joy_split    <= 1'b0;
                frame_strobe <= 1'b1;
              end
            end else begin
              // Next step k+1 drives SELECT high when k+1 is even
              joy_mdsel <= step[0];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_db9md_pad_reader.sv
// Bench for db9md_pad_reader: two behavioural Mega Drive pads on the muxed
// port, directed scenarios followed by randomized button frames.
module tb_db9md_pad_reader;

  localparam int unsigned S     = 8;
  localparam int unsigned I     = 40;
  localparam int unsigned SWAP0 = I + 8 * S;     // split rises here
  localparam int unsigned SCAN1 = I + 9 * S;     // player 2 scan begins
  localparam int unsigned FRAME = I + 17 * S;    // strobe offset from previous strobe

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  joy_in;
  logic        joy_mdsel;
  logic        joy_split;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  present;
  logic [1:0]  six_btn;
  logic        frame_strobe;

  int tests = 0;
  int failed = 0;

  db9md_pad_reader #(.STEP_CYCLES(S), .IDLE_CYCLES(I)) dut (
    .clk          (clk),
    .reset        (reset),
    .joy_in       (joy_in),
    .joy_mdsel    (joy_mdsel),
    .joy_split    (joy_split),
    .joystick1    (joystick1),
    .joystick2    (joystick2),
    .present      (present),
    .six_btn      (six_btn),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  // Pad state: buttons use the joystick word layout
  logic [11:0] btn [2];
  logic [1:0]  is6 = 2'b00;
  logic [1:0]  plugged = 2'b00;
  int          lows [2] = '{0, 0};
  int          hr [2] = '{100, 100};
  logic [1:0]  prev = 2'b11;
  logic [1:0]  psel;
  logic [5:0]  pout [2];

  // Each pad sees SELECT only while the mux points at it; a long high run
  // resets its internal select-edge counter
  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (psel[n] !== 1'b0) begin
        hr[n] <= hr[n] + 1;
        if (hr[n] >= 30) lows[n] <= 0;
        prev[n] <= 1'b1;
      end else begin
        hr[n] <= 0;
        if (prev[n]) lows[n] <= lows[n] + 1;
        prev[n] <= 1'b0;
      end
    end
  end

  // Pad line model, output order {D5,D4,D3,D2,D1,D0}, active-low
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      psel[n] = (joy_split === 1'(n)) ? joy_mdsel : 1'b1;
      pout[n] = 6'h3F;
      if (plugged[n]) begin
        if (psel[n] !== 1'b0) begin
          if (is6[n] && lows[n] == 3)
            pout[n] = {~btn[n][6], ~btn[n][5], ~btn[n][11], ~btn[n][7], ~btn[n][8], ~btn[n][9]};
          else
            pout[n] = {~btn[n][6], ~btn[n][5], ~btn[n][0], ~btn[n][1], ~btn[n][2], ~btn[n][3]};
        end else begin
          if (is6[n] && lows[n] == 3)
            pout[n] = {~btn[n][10], ~btn[n][4], 4'b0000};
          else if (is6[n] && lows[n] == 4)
            pout[n] = {~btn[n][10], ~btn[n][4], 4'b1111};
          else
            pout[n] = {~btn[n][10], ~btn[n][4], 2'b00, ~btn[n][2], ~btn[n][3]};
        end
      end
    end
  end

  assign joy_in = (joy_split === 1'b1) ? pout[1] : pout[0];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (frame_strobe !== 1'b1 && cyc < 1000);
    tests++;
    assert (frame_strobe === 1'b1) else begin
      failed++;
      $error("FAIL %s strobe_timeout observed=%b expected=1", tag, frame_strobe);
    end
  endtask

  // Expected committed word from the pad's plugged/button state
  function automatic logic [15:0] exp_word(input int n);
    return plugged[n] ? {4'h0, btn[n]} : 16'h0000;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "_j1"}, joystick1, exp_word(0));
    chk({tag, "_j2"}, joystick2, exp_word(1));
    chk({tag, "_present"}, 16'(present), 16'(plugged));
    chk({tag, "_six"}, 16'(six_btn), 16'(plugged & is6));
  endtask

  initial begin
    int          cyc;
    logic [11:0] b;
    logic        em;

    btn[0] = 12'h021;   // B + Right, 3-button
    btn[1] = 12'h000;
    is6 = 2'b00;
    plugged = 2'b01;

    repeat (3) @(negedge clk);
    chk("rst_j1", joystick1, 16'h0);
    chk("rst_j2", joystick2, 16'h0);
    chk("rst_present", 16'(present), 16'h0);
    chk("rst_six", 16'(six_btn), 16'h0);
    chk("rst_strobe", 16'(frame_strobe), 16'h0);
    chk("rst_mdsel", 16'(joy_mdsel), 16'h1);
    chk("rst_split", 16'(joy_split), 16'h0);
    reset = 1'b0;

    // First frame: 3-button pad on player 1, nothing on player 2
    wait_strobe("f1", cyc);
    chk("f1_period", 16'(cyc), 16'(FRAME));
    chk("f1_j1", joystick1, 16'h0021);
    chk("f1_j2", joystick2, 16'h0000);
    chk("f1_present", 16'(present), 16'h1);
    chk("f1_six", 16'(six_btn), 16'h0);

    // 6-button pad on player 2 with X + Mode + Start
    btn[1] = 12'hC80;
    is6[1] = 1'b1;
    plugged[1] = 1'b1;
    wait_strobe("f2", cyc);
    chk("f2_j2", joystick2, 16'h0C80);
    chk("f2_six1", 16'(six_btn[1]), 16'h1);
    chk("f2_present1", 16'(present[1]), 16'h1);
    chk("f2_j1", joystick1, 16'h0021);

    // SELECT / mux schedule over one full frame
    for (int t = 1; t <= int'(FRAME); t++) begin
      @(negedge clk);
      if (t < int'(I))          em = 1'b1;
      else if (t < int'(SWAP0)) em = (((t - int'(I)) / int'(S)) % 2) == 0;
      else if (t < int'(SCAN1)) em = 1'b1;
      else if (t < int'(FRAME)) em = (((t - int'(SCAN1)) / int'(S)) % 2) == 0;
      else                      em = 1'b1;
      chk($sformatf("mdsel@%0d", t), 16'(joy_mdsel), 16'(em));
      chk($sformatf("split@%0d", t), 16'(joy_split),
          16'((t >= int'(SWAP0)) && (t < int'(FRAME))));
      chk($sformatf("strobe@%0d", t), 16'(frame_strobe), 16'(t == int'(FRAME)));
    end

    // Reset during player 2, step 4
    repeat (SCAN1 + 4 * S + 2) @(negedge clk);
    chk("pre_rst_split", 16'(joy_split), 16'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_j1", joystick1, 16'h0);
    chk("mid_rst_j2", joystick2, 16'h0);
    chk("mid_rst_present", 16'(present), 16'h0);
    chk("mid_rst_six", 16'(six_btn), 16'h0);
    chk("mid_rst_strobe", 16'(frame_strobe), 16'h0);
    chk("mid_rst_mdsel", 16'(joy_mdsel), 16'h1);
    chk("mid_rst_split", 16'(joy_split), 16'h0);
    reset = 1'b0;
    wait_strobe("after_rst", cyc);
    chk("after_rst_period", 16'(cyc), 16'(FRAME));
    chk_all("after_rst");

    // Button release lands exactly at player 1's commit
    btn[0] = 12'h010;
    wait_strobe("rel_a", cyc);
    chk("rel_a_j1", joystick1, 16'h0010);
    btn[0] = 12'h000;
    repeat (SWAP0 - 1) @(negedge clk);
    chk("rel_hold_j1", joystick1, 16'h0010);
    @(negedge clk);
    chk("rel_drop_j1", joystick1, 16'h0000);
    wait_strobe("rel_b", cyc);
    chk_all("rel_b");

    // Player 2 unplugged mid-run
    btn[0] = 12'h021;
    repeat (60) @(negedge clk);
    plugged[1] = 1'b0;
    wait_strobe("unplug", cyc);
    chk("unplug_j1", joystick1, 16'h0021);
    chk("unplug_j2", joystick2, 16'h0000);
    chk("unplug_present", 16'(present), 16'h1);
    chk("unplug_six", 16'(six_btn), 16'h0);

    // Randomized pads and buttons, one change per frame
    for (int f = 0; f < 10; f++) begin
      for (int n = 0; n < 2; n++) begin
        plugged[n] = ($urandom_range(0, 3) != 0);
        is6[n] = 1'($urandom_range(0, 1));
        b = 12'($urandom);
        if (!is6[n]) begin
          b = b & 12'h47F;             // no X/Y/Z/Mode on a 3-button pad
          if (b[3] && b[2]) b[2] = 1'b0;  // U and D cannot both be held
        end
        btn[n] = b;
      end
      wait_strobe($sformatf("rnd%0d", f), cyc);
      chk($sformatf("rnd%0d_period", f), 16'(cyc), 16'(FRAME));
      chk_all($sformatf("rnd%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
